// File: rtl/word_mem_arbiter.sv
// Round-robin A/B sequencer for a single-port, byte-masked word memory; reads return registered after one cycle.
// Defining WMEM_CLEAR_EN adds a post-reset sweep that zeroes every line before any grant is issued.
module word_mem_arbiter #(
   parameter int LINES   = 16,
   parameter int SETBITS = $clog2(LINES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               a_req,
   input  logic               a_we,
   input  logic [SETBITS-1:0] a_set,
   input  logic [3:0]         a_mask,
   input  logic [31:0]        a_wd,
   output logic               a_gnt,
   output logic               a_rvalid,
   output logic [31:0]        a_rd,
   input  logic               b_req,
   input  logic               b_we,
   input  logic [SETBITS-1:0] b_set,
   input  logic [3:0]         b_mask,
   input  logic [31:0]        b_wd,
   output logic               b_gnt,
   output logic               b_rvalid,
   output logic [31:0]        b_rd,
   output logic               mem_we,
   output logic [SETBITS-1:0] mem_set,
   output logic [3:0]         mem_mask,
   output logic [31:0]        mem_wd,
   input  logic [31:0]        mem_rd,
   output logic               busy
);

   logic               run;
   logic               clearing;
   logic [SETBITS-1:0] clr_set;
   logic               last_b;
   logic               a_pend;
   logic               b_pend;

`ifdef WMEM_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   state_t             state, state_nxt;
   logic [SETBITS-1:0] clr_cnt, clr_cnt_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      if (state == ST_CLEAR) begin
         if (clr_cnt == SETBITS'(LINES - 1)) begin
            state_nxt   = ST_RUN;
            clr_cnt_nxt = '0;
         end else begin
            clr_cnt_nxt = clr_cnt + SETBITS'(1);
         end
      end
   end

   // Reset gating keeps the sweep write off the memory bus while reset_n is held low.
   assign clearing = reset_n && (state == ST_CLEAR);
   assign run      = reset_n && (state == ST_RUN);
   assign busy     = (state == ST_CLEAR);
   assign clr_set  = clr_cnt;
`else
   assign clearing = 1'b0;
   assign run      = reset_n;
   assign busy     = 1'b0;
   assign clr_set  = '0;
`endif

   // On a tie the port that did not win last time goes first.
   assign a_gnt = run && a_req && (!b_req || last_b);
   assign b_gnt = run && b_req && !a_gnt;

   always_comb begin
      mem_we   = 1'b0;
      mem_set  = '0;
      mem_mask = 4'b0000;
      mem_wd   = 32'h0;
      if (clearing) begin
         mem_we   = 1'b1;
         mem_set  = clr_set;
         mem_mask = 4'b1111;
      end else if (a_gnt) begin
         mem_we   = a_we;
         mem_set  = a_set;
         mem_mask = a_mask;
         mem_wd   = a_wd;
      end else if (b_gnt) begin
         mem_we   = b_we;
         mem_set  = b_set;
         mem_mask = b_mask;
         mem_wd   = b_wd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_b <= 1'b1;
         a_pend <= 1'b0;
         b_pend <= 1'b0;
         a_rd   <= 32'h0;
         b_rd   <= 32'h0;
      end else begin
         if (a_gnt) begin
            last_b <= 1'b0;
         end else if (b_gnt) begin
            last_b <= 1'b1;
         end
         a_pend <= a_gnt && !a_we;
         b_pend <= b_gnt && !b_we;
         if (a_gnt && !a_we) begin
            a_rd <= mem_rd;
         end
         if (b_gnt && !b_we) begin
            b_rd <= mem_rd;
         end
      end
   end

   assign a_rvalid = a_pend;
   assign b_rvalid = b_pend;

endmodule

// File: tb/tb_word_mem_arbiter.sv
// Directed bench for word_mem_arbiter with a behavioural byte-masked memory behind the mem_* port.
module tb_word_mem_arbiter;

`ifdef WMEM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_req, a_we, a_gnt, a_rvalid;
   logic [3:0]  a_set, a_mask;
   logic [31:0] a_wd, a_rd;
   logic        b_req, b_we, b_gnt, b_rvalid;
   logic [3:0]  b_set, b_mask;
   logic [31:0] b_wd, b_rd;
   logic        mem_we, busy;
   logic [3:0]  mem_set, mem_mask;
   logic [31:0] mem_wd, mem_rd;
   logic        preset;
   logic [31:0] mem [16];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   word_mem_arbiter #(.LINES(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_set(a_set), .a_mask(a_mask), .a_wd(a_wd),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rd(a_rd),
      .b_req(b_req), .b_we(b_we), .b_set(b_set), .b_mask(b_mask), .b_wd(b_wd),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rd(b_rd),
      .mem_we(mem_we), .mem_set(mem_set), .mem_mask(mem_mask), .mem_wd(mem_wd),
      .mem_rd(mem_rd), .busy(busy)
   );

   assign mem_rd = mem[mem_set];

   always @(posedge clk) begin
      if (preset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5A5A5;
      end else if (mem_we) begin
         for (int k = 0; k < 4; k++)
            if (mem_mask[k]) mem[mem_set][8*k +: 8] <= mem_wd[8*k +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sweep(input int n);
      for (int i = 0; i < n; i++) begin
         check("sweep_busy", 32'(busy), 32'd1);
         check("sweep_set", 32'(mem_set), 32'(i));
         check("sweep_we", 32'(mem_we), 32'd1);
         check("sweep_mask", 32'(mem_mask), 32'hF);
         check("sweep_wd", mem_wd, 32'h0);
         check("sweep_no_gnt", 32'({a_gnt, b_gnt}), 32'd0);
         @(negedge clk); #1;
      end
   endtask

   // Single-port access: drive, check the same-cycle command, then the next-cycle return.
   task automatic access(input bit pb, input bit we, input logic [3:0] set, input logic [3:0] mask,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
      if (pb) begin b_req = 1; b_we = we; b_set = set; b_mask = mask; b_wd = wd; end
      else    begin a_req = 1; a_we = we; a_set = set; a_mask = mask; a_wd = wd; end
      #1;
      check("acc_gnt", 32'({a_gnt, b_gnt}), pb ? 32'd1 : 32'd2);
      check("acc_mem_we", 32'(mem_we), 32'(we));
      check("acc_mem_set", 32'(mem_set), 32'(set));
      check("acc_mem_mask", 32'(mem_mask), 32'(mask));
      if (we) check("acc_mem_wd", mem_wd, wd);
      @(negedge clk);
      a_req = 0; b_req = 0;
      #1;
      check("acc_rvalid", 32'(pb ? b_rvalid : a_rvalid), 32'(!we));
      if (!we) check("acc_rd", pb ? b_rd : a_rd, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; preset = 1;
      a_req = 1; a_we = 0; a_set = 0; a_mask = 0; a_wd = 0;
      b_req = 1; b_we = 0; b_set = 0; b_mask = 0; b_wd = 0;
      @(negedge clk); @(negedge clk); #1;
      preset = 0;
      check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_mask", 32'(mem_mask), 32'd0);
      check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      check("rst_a_rd", a_rd, 32'h0);
      check("rst_b_rd", b_rd, 32'h0);
      check("rst_busy", 32'(busy), 32'(CLR));

      // A read of set 5 is held through the sweep.
      b_req = 0; a_req = 1; a_we = 0; a_set = 4'd5;
      @(negedge clk); reset_n = 1; #1;
      if (CLR) sweep(16);
      check("run_busy", 32'(busy), 32'd0);
      check("first_gnt", 32'({a_gnt, b_gnt}), 32'd2);
      check("first_set", 32'(mem_set), 32'd5);
      @(negedge clk); a_req = 0; #1;
      check("first_rvalid", 32'(a_rvalid), 32'd1);
      check("first_rd", a_rd, CLR ? 32'h0 : 32'hA5A5A5A5);
      @(negedge clk); #1;
      check("rvalid_pulse", 32'(a_rvalid), 32'd0);

      access(0, 1, 4'd3, 4'b1111, 32'hDEADBEEF, 32'h0);
      check("rd_hold", a_rd, CLR ? 32'h0 : 32'hA5A5A5A5);
      access(1, 1, 4'd3, 4'b0100, 32'h00AA0000, 32'h0);
      access(0, 0, 4'd3, 4'b1111, 32'h0, 32'hDEAABEEF);

      access(0, 1, 4'd7, 4'b1111, 32'h12345678, 32'h0);
      access(0, 0, 4'd7, 4'b1111, 32'h0, 32'h12345678);

      access(0, 1, 4'd2, 4'b1111, 32'hCAFEF00D, 32'h0);
      access(0, 1, 4'd2, 4'b0000, 32'hFFFFFFFF, 32'h0);
      access(0, 0, 4'd2, 4'b0000, 32'h0, 32'hCAFEF00D);

      // A B-grant first makes A the tie winner for the contention run.
      access(1, 0, 4'd3, 4'b0000, 32'h0, 32'hDEAABEEF);
      a_req = 1; a_we = 0; a_set = 4'd7;
      b_req = 1; b_we = 0; b_set = 4'd2;
      #1;
      for (int c = 0; c < 6; c++) begin
         check("rr_gnt", 32'({a_gnt, b_gnt}), (c % 2 == 0) ? 32'd2 : 32'd1);
         if (c > 0) check("rr_rvalid", 32'({a_rvalid, b_rvalid}), (c % 2 == 1) ? 32'd2 : 32'd1);
         @(negedge clk); #1;
      end
      a_req = 0; b_req = 0;
      check("rr_last_rvalid", 32'({a_rvalid, b_rvalid}), 32'd1);
      check("rr_a_rd", a_rd, 32'h12345678);
      check("rr_b_rd", b_rd, 32'hCAFEF00D);

      // Same-cycle A write and B read of set 4.
      @(negedge clk);
      a_req = 1; a_we = 1; a_set = 4'd4; a_mask = 4'b1111; a_wd = 32'h11112222;
      b_req = 1; b_we = 0; b_set = 4'd4;
      #1;
      check("tie_gnt_a", 32'({a_gnt, b_gnt}), 32'd2);
      @(negedge clk); a_req = 0; #1;
      check("tie_gnt_b", 32'({a_gnt, b_gnt}), 32'd1);
      check("tie_a_rvalid", 32'(a_rvalid), 32'd0);
      @(negedge clk); b_req = 0; #1;
      check("tie_b_rvalid", 32'(b_rvalid), 32'd1);
      check("tie_b_rd", b_rd, 32'h11112222);

      // Reset while a read return is pending.
      @(negedge clk);
      a_req = 1; a_we = 0; a_set = 4'd7;
      #1;
      check("mid_gnt", 32'(a_gnt), 32'd1);
      @(posedge clk); #1;
      check("mid_rvalid", 32'(a_rvalid), 32'd1);
      reset_n = 0; #1;
      check("mid_rst_rvalid", 32'(a_rvalid), 32'd0);
      check("mid_rst_rd", a_rd, 32'h0);
      check("mid_rst_gnt", 32'(a_gnt), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'(CLR));
      @(negedge clk); reset_n = 1; #1;
      if (CLR) begin
         sweep(9);
         check("sweep9_set", 32'(mem_set), 32'd9);
         reset_n = 0; #1;
         check("sweep_rst_we", 32'(mem_we), 32'd0);
         check("sweep_rst_mask", 32'(mem_mask), 32'd0);
         check("sweep_rst_busy", 32'(busy), 32'd1);
         @(negedge clk); reset_n = 1; #1;
         sweep(16);
      end
      check("post_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk); a_req = 0; #1;
      check("post_rvalid", 32'(a_rvalid), 32'd1);
      check("post_rd", a_rd, CLR ? 32'h0 : 32'h12345678);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/word_mem_arbiter.md
# word_mem_arbiter

Sequencer and two-requester round-robin arbiter for a single-ported, byte-masked word memory (lines × 32 bits, asynchronous read, byte-masked synchronous write). It sits between the memory array and two clients, port A (CPU data access) and port B (line-fill / maintenance engine), and issues at most one memory operation per cycle. It registers read data back to the winning requester. An optional post-reset sweep zeroes every line before any client is served.

## Interface
Parameters:
- LINES, 16, number of memory lines.
- SETBITS, $clog2(LINES), line index width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held with fields stable until granted.
- a_we  in  1  port A write (1) / read (0).
- a_set  in  SETBITS  port A line index.
- a_mask  in  4  port A byte mask, bit i enables wd[8i+7:8i].
- a_wd  in  32  port A write data.
- a_gnt  out  1  port A accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid (one-cycle pulse).
- a_rd  out  32  port A read data.
- b_req, b_we, b_set, b_mask, b_wd, b_gnt, b_rvalid, b_rd: same as port A, for port B.
- mem_we  out  1  memory write enable.
- mem_set  out  SETBITS  memory line index.
- mem_mask  out  4  memory byte mask.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory asynchronous read data for mem_set.
- busy  out  1  clear sweep in progress; no grants.

## Operation
- States: CLEAR (only with WMEM_CLEAR_EN) and RUN. Reset enters CLEAR if compiled in, otherwise RUN.
- RUN arbitration:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the port not granted most recently.
  - Priority register `last` updates only on an accepted grant. Reset value: last = B, so A wins the first tie.
  - No request: gnt both 0, mem_we 0, mem_mask 0, mem_set/mem_wd 0.
- Memory command: the granted port's set, mask and wd drive the mem_* outputs combinationally. mem_we equals the granted port's we.
- A write with mask 4'b0000 is accepted and granted, with mem_we=1 and no bytes changed.
- Read return: on an accepted read, mem_rd is captured at the next rising edge into that port's rd register. The matching rvalid is high for exactly that following cycle. Writes never assert rvalid.
- The rd register holds its last value until the next read to that port.
- Ordering: accesses are serialized. A read in cycle N+1 of a set written in cycle N returns the new data. A same-cycle A write and B read of one set resolve in grant order.
- CLEAR: a counter walks set 0..LINES-1, one line per cycle, driving mem_we=1, mask 4'b1111, wd=0, with busy=1 and both gnt=0. After line LINES-1 is written, the state goes to RUN. Requests are held by clients, not dropped.

## Timing
- Values while reset_n is low: a_gnt=b_gnt=0, mem_we=0, mem_mask=0, a_rvalid=b_rvalid=0, a_rd=b_rd=0, clear counter=0, last=B. busy=1 if WMEM_CLEAR_EN, else 0.
- Grant latency: 0 cycles, same cycle as req when the arbiter is free.
- Write commits at the edge ending the grant cycle.
- Read latency: 1 cycle, rvalid in the cycle after grant.
- Throughput: one access per cycle. Under continuous contention, A and B alternate.
- CLEAR duration: exactly LINES cycles after reset_n rises. First grant is possible in cycle LINES.
- Reset asserted mid-sweep or mid-transaction: all state is re-initialized immediately. A pending rvalid is cancelled. The sweep restarts at set 0.

## Configuration
- WMEM_CLEAR_EN defined: the CLEAR state, sweep counter and busy logic are compiled in, and memory contents are zero when RUN is first entered.
- WMEM_CLEAR_EN undefined: reset goes directly to RUN and busy is tied 0. Memory contents are undefined until written, and grants are possible in the first cycle after reset_n rises.

## Test plan
- Reset with WMEM_CLEAR_EN, LINES=16 -> busy=1 for 16 cycles with mem_set 0..15, mem_we=1, mask 1111, wd 0. Then A read of set 5 -> a_rvalid next cycle with a_rd=0x00000000.
- A writes set 3 = 0xDEADBEEF, mask 1111, then B writes set 3 = 0x00AA0000, mask 0100. Then A reads set 3 -> a_rd=0xDEAABEEF.
- A and B request continuously for 6 cycles -> grants A,B,A,B,A,B with exactly one gnt per cycle.
- A write set 7 = 0x12345678 in cycle N, A read set 7 in cycle N+1 -> a_rvalid in N+2 with a_rd=0x12345678.
- A write with mask 0000 to set 2 that holds 0xCAFEF00D -> a_gnt=1, mem_we=1. A subsequent read of set 2 returns 0xCAFEF00D.
- Assert reset_n low at sweep line 9 -> outputs take reset values immediately. After release, the sweep restarts at set 0 and lasts 16 cycles.
